ln_sample_sequencer: RTL and testbench
======================================

// Module: ln_sample_sequencer
// PURPOSE
//  Synthesizable initiator for the LINEALIZADOR_NORMALIZADOR block. Replaces the bench-side driving logic.
//  Accepts I/V float samples on a valid/ready stream and clears the unit with RST_LN_FF.
//  Loads I/V, pulses Begin_FSM_I/V, and waits for both ACKs.
//  Captures RESULT_I/V and presents them on a one-entry valid/ready output stream.
// PARAMETERS
//  P           32    data width of I, V, RESULT_I, RESULT_V (IEEE-754 single)
//  RST_CYCLES  4     cycles RST_LN_FF held high before each sample (>=1)
//  TIMEOUT     2500  max WAIT cycles before abort (only with SEQ_TIMEOUT_EN)
//  CNT_W       16    width of SAMPLE_CNT
// PORTS
//  CLK           in   1      system clock, all logic on posedge
//  RST_SEQ_N     in   1      synchronous reset, active low
//  IN_VALID      in   1      input sample valid
//  IN_READY      out  1      sequencer can accept a sample
//  IN_I          in   P      current sample
//  IN_V          in   P      voltage sample
//  I             out  P      to linearizer I
//  V             out  P      to linearizer V
//  RST_LN_FF     out  1      linearizer reset, active high
//  Begin_FSM_I   out  1      start pulse, current path
//  Begin_FSM_V   out  1      start pulse, voltage path
//  ACK_I         in   1      current path done (level, held until RST_LN_FF)
//  ACK_V         in   1      voltage path done (level, held until RST_LN_FF)
//  RESULT_I      in   P      current result, valid while ACK_I high
//  RESULT_V      in   P      voltage result, valid while ACK_V high
//  OUT_VALID     out  1      result pair available
//  OUT_READY     in   1      downstream accepts result
//  OUT_I         out  P      captured RESULT_I
//  OUT_V         out  P      captured RESULT_V
//  ERR_TIMEOUT   out  1      sticky abort flag
//  SAMPLE_CNT    out  CNT_W  count of results delivered, wraps at 2**CNT_W
// BEHAVIOUR
//  Reset (RST_SEQ_N=0 at posedge):
//   - State goes to IDLE. RST_LN_FF=1; every other output is 0.
//   - Reset mid-sample abandons the sample silently.
//  States:
//   - IDLE: IN_READY=1. On IN_VALID&IN_READY, latch IN_I/IN_V into I/V; go to CLR.
//   - CLR: RST_LN_FF=1 for RST_CYCLES cycles; clear the ACK_I/ACK_V capture flags; go to START.
//   - START: RST_LN_FF=0; Begin_FSM_I=Begin_FSM_V=1 for exactly 1 cycle; go to WAIT.
//   - WAIT: on the first cycle ACK_I=1, capture RESULT_I into OUT_I and set flag_i (same rule for V).
//     ACKs may arrive in any order or in the same cycle; later ACK highs don't recapture.
//     When both flags are set: OUT_VALID=1 the next cycle; go to DONE.
//   - DONE: hold OUT_*. On OUT_VALID&OUT_READY: OUT_VALID=0, SAMPLE_CNT+=1, go to IDLE.
//     OUT_READY already high on entry -> handshake completes in the first DONE cycle.
//  Output/handshake rules:
//   - I/V stay stable from latch until the next accepted sample.
//   - IN_READY=0 in every state except IDLE.
//   - Begin_FSM_* never high while RST_LN_FF=1.
//  Latency: accept cycle t -> Begin at t+1+RST_CYCLES -> OUT_VALID 1 cycle after the later ACK.
//  ACK high in CLR or START (stale) is ignored.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined:
//   - A WAIT cycle counter runs; reaching TIMEOUT with either flag clear sets ERR_TIMEOUT=1.
//   - The sample is dropped: no OUT_VALID, SAMPLE_CNT unchanged; go to CLR->IDLE with RST_LN_FF pulsed.
//   - ERR_TIMEOUT clears only on reset.
//  SEQ_TIMEOUT_EN undefined: WAIT is unbounded; ERR_TIMEOUT tied 0; no counter logic.
// TESTING
//  1. IN_I=32'h3F800000, IN_V=32'h40000000; model ACKs both 40 cycles after Begin, RESULT_I=32'h3E800000,
//     RESULT_V=32'h3F000000 -> I/V equal the inputs, OUT_I=32'h3E800000, OUT_V=32'h3F000000, SAMPLE_CNT=1.
//  2. ACK_I at +10, ACK_V at +300, RESULT_I changes after its ACK -> OUT_I holds the +10 value;
//     OUT_VALID exactly 1 cycle after ACK_V.
//  3. OUT_READY=0 for 50 cycles, IN_VALID=1 throughout -> IN_READY=0, OUT_* stable;
//     second sample accepted only after the handshake.
//  4. Reset asserted in WAIT -> next posedge RST_LN_FF=1, OUT_VALID=0, SAMPLE_CNT=0, IN_READY=0;
//     after release IN_READY=1.
//  5. (SEQ_TIMEOUT_EN, TIMEOUT=2500) ACK_V never arrives -> ERR_TIMEOUT=1 at WAIT cycle 2500;
//     no OUT_VALID; RST_LN_FF pulses RST_CYCLES; next sample completes normally.
//  6. Stream 1024 back-to-back samples from file -> 1024 result pairs in order, SAMPLE_CNT=1024,
//     Begin_FSM_* count=1024.

Source files
------------

// File: rtl/ln_sample_sequencer.sv
// ln_sample_sequencer: runs one LINEALIZADOR_NORMALIZADOR conversion per I/V sample; define SEQ_TIMEOUT_EN for the WAIT abort
`timescale 1ns/1ps
module ln_sample_sequencer #(
    parameter int P          = 32,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 2500,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RST_SEQ_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [P-1:0]     IN_I,
    input  logic [P-1:0]     IN_V,
    output logic [P-1:0]     I,
    output logic [P-1:0]     V,
    output logic             RST_LN_FF,
    output logic             Begin_FSM_I,
    output logic             Begin_FSM_V,
    input  logic             ACK_I,
    input  logic             ACK_V,
    input  logic [P-1:0]     RESULT_I,
    input  logic [P-1:0]     RESULT_V,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [P-1:0]     OUT_I,
    output logic [P-1:0]     OUT_V,
    output logic             ERR_TIMEOUT,
    output logic [CNT_W-1:0] SAMPLE_CNT
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0] R_LAST = RW'(RST_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, CLR, START, WAIT, DONE} state_t;
    state_t state;
    logic [RW-1:0] rcnt;
    logic flag_i, flag_v, both;
`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tcnt;
    logic abort;
`else
    assign ERR_TIMEOUT = TIMEOUT < 0;
`endif
    assign both = (flag_i | ACK_I) & (flag_v | ACK_V);
    // Sequencer FSM: every output is a register updated on the transition into the state that owns it
    always_ff @(posedge CLK) begin
        if (!RST_SEQ_N) begin
            state       <= IDLE;
            rcnt        <= '0;
            flag_i      <= 1'b0;
            flag_v      <= 1'b0;
            IN_READY    <= 1'b0;
            I           <= '0;
            V           <= '0;
            RST_LN_FF   <= 1'b1;
            Begin_FSM_I <= 1'b0;
            Begin_FSM_V <= 1'b0;
            OUT_VALID   <= 1'b0;
            OUT_I       <= '0;
            OUT_V       <= '0;
            SAMPLE_CNT  <= '0;
`ifdef SEQ_TIMEOUT_EN
            tcnt        <= '0;
            abort       <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID && IN_READY) begin
                        I         <= IN_I;
                        V         <= IN_V;
                        IN_READY  <= 1'b0;
                        RST_LN_FF <= 1'b1;
                        rcnt      <= '0;
                        state     <= CLR;
                    end else begin
                        IN_READY <= 1'b1;
                    end
                end
                CLR: begin
                    flag_i <= 1'b0;
                    flag_v <= 1'b0;
                    if (rcnt == R_LAST) begin
                        RST_LN_FF <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                        if (abort) begin
                            abort    <= 1'b0;
                            IN_READY <= 1'b1;
                            state    <= IDLE;
                        end else begin
`else
                        begin
`endif
                            Begin_FSM_I <= 1'b1;
                            Begin_FSM_V <= 1'b1;
                            state       <= START;
                        end
                    end else begin
                        rcnt <= rcnt + RW'(1);
                    end
                end
                START: begin
                    Begin_FSM_I <= 1'b0;
                    Begin_FSM_V <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
                    tcnt        <= '0;
`endif
                    state       <= WAIT;
                end
                WAIT: begin
                    if (ACK_I && !flag_i) begin
                        OUT_I  <= RESULT_I;
                        flag_i <= 1'b1;
                    end
                    if (ACK_V && !flag_v) begin
                        OUT_V  <= RESULT_V;
                        flag_v <= 1'b1;
                    end
                    if (both) begin
                        OUT_VALID <= 1'b1;
                        state     <= DONE;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (tcnt == T_LAST) begin
                        ERR_TIMEOUT <= 1'b1;
                        abort       <= 1'b1;
                        RST_LN_FF   <= 1'b1;
                        rcnt        <= '0;
                        state       <= CLR;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID  <= 1'b0;
                        SAMPLE_CNT <= SAMPLE_CNT + CNT_W'(1);
                        IN_READY   <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ln_sample_sequencer.sv
// tb_ln_sample_sequencer: scoreboard bench for ln_sample_sequencer driving a behavioural linearizer model
`timescale 1ns/1ps
module tb_ln_sample_sequencer;
    localparam int RC = 4;
    logic CLK = 1'b0, RST_SEQ_N = 1'b0, IN_VALID = 1'b0, ACK_I = 1'b0, ACK_V = 1'b0, OUT_READY = 1'b1;
    logic [31:0] IN_I = '0, IN_V = '0, RESULT_I = 32'hDEADBEEF, RESULT_V = 32'hDEADBEEF;
    logic IN_READY, RST_LN_FF, Begin_FSM_I, Begin_FSM_V, OUT_VALID, ERR_TIMEOUT;
    logic [31:0] I, V, OUT_I, OUT_V;
    logic [15:0] SAMPLE_CNT;
    typedef struct { logic [31:0] ii, iv, ri, rv; logic [15:0] cnt; } exp_t;
    typedef struct { logic [31:0] ri, rv; int di, dv; } lin_t;
    exp_t sb[$];
    lin_t lin_q[$];
    lin_t cur;
    int checks = 0, passed = 0, cyc = 0, acki_cyc = 0, ackv_cyc = 0, ti = -1, tv = -1;
    int begins_i = 0, begins_v = 0, bad_begin = 0, n_cnt = 0;
    bit prev_ov = 1'b0;

    ln_sample_sequencer #(.RST_CYCLES(RC)) dut (
        .CLK(CLK), .RST_SEQ_N(RST_SEQ_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_I(IN_I), .IN_V(IN_V), .I(I), .V(V), .RST_LN_FF(RST_LN_FF),
        .Begin_FSM_I(Begin_FSM_I), .Begin_FSM_V(Begin_FSM_V), .ACK_I(ACK_I), .ACK_V(ACK_V),
        .RESULT_I(RESULT_I), .RESULT_V(RESULT_V), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_I(OUT_I), .OUT_V(OUT_V), .ERR_TIMEOUT(ERR_TIMEOUT), .SAMPLE_CNT(SAMPLE_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Linearizer model: ACKs after the queued delays, RESULT_* valid only on the ACK cycle
    initial forever begin
        @(posedge CLK);
        #1;
        if (RST_LN_FF === 1'b1 && (Begin_FSM_I === 1'b1 || Begin_FSM_V === 1'b1)) bad_begin++;
        if (RST_LN_FF === 1'b1) begin
            ACK_I = 1'b0;
            ACK_V = 1'b0;
            ti = -1;
            tv = -1;
            RESULT_I = 32'hDEADBEEF;
            RESULT_V = 32'hDEADBEEF;
        end else if (Begin_FSM_I === 1'b1 || Begin_FSM_V === 1'b1) begin
            begins_i += int'(Begin_FSM_I);
            begins_v += int'(Begin_FSM_V);
            if (lin_q.size() > 0) begin
                cur = lin_q.pop_front();
                ti = cur.di;
                tv = cur.dv;
            end
        end else begin
            if (ACK_I) RESULT_I = ~cur.ri;
            if (ACK_V) RESULT_V = ~cur.rv;
            if (ti > 0) begin
                ti--;
                if (ti == 0) begin ACK_I = 1'b1; RESULT_I = cur.ri; acki_cyc = cyc; ti = -1; end
            end
            if (tv > 0) begin
                tv--;
                if (tv == 0) begin ACK_V = 1'b1; RESULT_V = cur.rv; ackv_cyc = cyc; tv = -1; end
            end
        end
    end

    // Monitor: latency of OUT_VALID and scoreboard compare on each output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST_SEQ_N !== 1'b1) begin
                prev_ov = 1'b0;
            end else begin
                if (OUT_VALID === 1'b1 && !prev_ov)
                    chk(cyc == (acki_cyc > ackv_cyc ? acki_cyc : ackv_cyc) + 1, "out_latency", 128'(cyc),
                        128'((acki_cyc > ackv_cyc ? acki_cyc : ackv_cyc) + 1));
                prev_ov = OUT_VALID;
                if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                    chk(sb.size() > 0, "unexpected_out", 128'(sb.size()), 128'(1));
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk({OUT_I, OUT_V} === {e.ri, e.rv}, "out_pair", {OUT_I, OUT_V}, {e.ri, e.rv});
                        chk({I, V} === {e.ii, e.iv}, "iv_hold", {I, V}, {e.ii, e.iv});
                        chk(SAMPLE_CNT === e.cnt, "sample_cnt", SAMPLE_CNT, e.cnt);
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] ii, iv, ri, rv, input int di, dv, input bit expd);
        lin_t l;
        exp_t e;
        int n;
        n = 0;
        l.ri = ri; l.rv = rv; l.di = di; l.dv = dv;
        lin_q.push_back(l);
        if (expd) begin
            e.ii = ii; e.iv = iv; e.ri = ri; e.rv = rv; e.cnt = 16'(n_cnt);
            n_cnt++;
            sb.push_back(e);
        end
        IN_I = ii;
        IN_V = iv;
        IN_VALID = 1'b1;
        do begin
            @(negedge CLK);
            n++;
        end while (IN_READY !== 1'b1 && n < 3000);
        chk(IN_READY === 1'b1, "accept", 128'(IN_READY), 128'(1));
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        chk(sb.size() == 0, "drain", 128'(sb.size()), 128'(0));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int n, bad, b0, bv0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk({RST_LN_FF, IN_READY, OUT_VALID} === 3'b100, "rst_ctl", {RST_LN_FF, IN_READY, OUT_VALID}, 3'b100);
        chk({Begin_FSM_I, Begin_FSM_V, ERR_TIMEOUT} === 3'b000, "rst_flags", {Begin_FSM_I, Begin_FSM_V, ERR_TIMEOUT}, 0);
        chk(SAMPLE_CNT === 16'd0, "rst_cnt", SAMPLE_CNT, 0);
        chk({I, V, OUT_I, OUT_V} === 128'h0, "rst_data", {I, V, OUT_I, OUT_V}, 0);
        @(posedge CLK);
        #1;
        RST_SEQ_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        send(32'h3F800000, 32'h40000000, 32'h3E800000, 32'h3F000000, 40, 40, 1'b1);
        drain();
        chk(SAMPLE_CNT === 16'd1, "t1_cnt", SAMPLE_CNT, 1);
        send(32'h40400000, 32'hC0000000, 32'h3F400000, 32'h3EAAAAAB, 10, 300, 1'b1);
        drain();
        OUT_READY = 1'b0;
        send(32'h40400000, 32'h40800000, 32'h3DCCCCCD, 32'h3E4CCCCD, 5, 8, 1'b1);
        fork
            send(32'h40A00000, 32'h40C00000, 32'h3C23D70A, 32'h3CA3D70A, 3, 3, 1'b1);
            begin
                n = 0;
                bad = 0;
                while (OUT_VALID !== 1'b1 && n < 500) begin
                    @(negedge CLK);
                    n++;
                end
                chk(OUT_VALID === 1'b1, "t3_valid", 128'(OUT_VALID), 128'(1));
                repeat (50) begin
                    @(negedge CLK);
                    if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1 || OUT_I !== 32'h3DCCCCCD ||
                        OUT_V !== 32'h3E4CCCCD || I !== 32'h40400000 || V !== 32'h40800000) bad++;
                end
                chk(bad == 0, "t3_stall", 128'(bad), 128'(0));
                @(posedge CLK);
                #1;
                OUT_READY = 1'b1;
            end
        join
        drain();
        chk(SAMPLE_CNT === 16'd4, "t3_cnt", SAMPLE_CNT, 4);
        send(32'h41000000, 32'h41100000, 32'h11111111, 32'h22222222, 100, 100, 1'b0);
        repeat (RC + 12) @(posedge CLK);
        #1;
        RST_SEQ_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk({RST_LN_FF, OUT_VALID, IN_READY} === 3'b100, "t4_rst_ctl", {RST_LN_FF, OUT_VALID, IN_READY}, 3'b100);
        chk(SAMPLE_CNT === 16'd0, "t4_cnt", SAMPLE_CNT, 0);
        @(posedge CLK);
        #1;
        RST_SEQ_N = 1'b1;
        n_cnt = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk(IN_READY === 1'b1, "t4_ready", 128'(IN_READY), 128'(1));
        @(posedge CLK);
        #1;
        b0 = begins_i;
        bv0 = begins_v;
        for (int k = 0; k < 1024; k++)
            send(32'h3F800000 + k, 32'h40000000 + 3 * k, 32'h3E800000 ^ k, 32'h3F000000 + 5 * k,
                 1 + k % 3, 1 + (k * 7) % 5, 1'b1);
        drain();
        chk(SAMPLE_CNT === 16'd1024, "t6_cnt", SAMPLE_CNT, 1024);
        chk(begins_i - b0 == 1024 && begins_v - bv0 == 1024, "t6_begins",
            128'(begins_i - b0), 128'(1024));
`ifdef SEQ_TIMEOUT_EN
        send(32'h3F800000, 32'h3F800000, 32'h01020304, 32'h05060708, 5, 1000000, 1'b0);
        n = 0;
        while (ERR_TIMEOUT !== 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk(ERR_TIMEOUT === 1'b1, "t5_err", 128'(ERR_TIMEOUT), 128'(1));
        n = 0;
        while (RST_LN_FF === 1'b1 && n < 100) begin
            n++;
            @(negedge CLK);
        end
        chk(n == RC, "t5_rst_pulse", 128'(n), 128'(RC));
        chk(SAMPLE_CNT === 16'd1024, "t5_cnt_hold", SAMPLE_CNT, 1024);
        @(posedge CLK);
        #1;
        send(32'h40000000, 32'h40400000, 32'h3F000000, 32'h3EAAAAAB, 4, 6, 1'b1);
        drain();
        chk(ERR_TIMEOUT === 1'b1, "t5_sticky", 128'(ERR_TIMEOUT), 128'(1));
`endif
        chk(bad_begin == 0, "begin_in_rst", 128'(bad_begin), 128'(0));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
